// File: rtl/lab1_seq_ctrl.sv
// Sequencer that walks the 3-in/2-out Lab 1 logic block through all
// 8 input vectors, samples z_0/z_1 after SETTLE cycles and reports.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        run control (start from IDLE/DONE, abort while busy)
//   x_0..x_2            vector driven to the logic block (registered)
//   z_0, z_1            outputs of the logic block
//   busy, done, pass    run status (registered)
//   err_cnt, fail_map   number and map of failing vectors
//   first_fail          lowest failing vector index (0 if none)
//   z0_map, z1_map      captured z_0 / z_1 per vector
module lab1_seq_ctrl #(
  parameter int unsigned SETTLE = 3,
  parameter logic [7:0]  EXP_Z0 = 8'hA5,
  parameter logic [7:0]  EXP_Z1 = 8'hF1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       x_0,
  output logic       x_1,
  output logic       x_2,
  input  logic       z_0,
  input  logic       z_1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_map,
  output logic [2:0] first_fail,
  output logic [7:0] z0_map,
  output logic [7:0] z1_map
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  state_t     state, state_n;
  logic [2:0] takt, takt_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] x_q, x_n;
  logic       busy_n, done_n, pass_n;
  logic [3:0] err_n;
  logic [7:0] fail_n;
  logic [2:0] first_n;
  logic [7:0] z0m_n, z1m_n;
  logic       mismatch;

  assign x_0 = x_q[0];
  assign x_1 = x_q[1];
  assign x_2 = x_q[2];

  assign mismatch = (z_0 != EXP_Z0[takt]) |
                    (z_1 != EXP_Z1[takt]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      takt       <= '0;
      cnt        <= '0;
      x_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_map   <= '0;
      first_fail <= '0;
      z0_map     <= '0;
      z1_map     <= '0;
    end else begin
      state      <= state_n;
      takt       <= takt_n;
      cnt        <= cnt_n;
      x_q        <= x_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_cnt    <= err_n;
      fail_map   <= fail_n;
      first_fail <= first_n;
      z0_map     <= z0m_n;
      z1_map     <= z1m_n;
    end
  end

  always_comb begin
    state_n = state;
    takt_n  = takt;
    cnt_n   = cnt;
    pass_n  = pass;
    err_n   = err_cnt;
    fail_n  = fail_map;
    first_n = first_fail;
    z0m_n   = z0_map;
    z1m_n   = z1_map;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = WAIT;
          takt_n  = '0;
          cnt_n   = '0;
          pass_n  = 1'b0;
          err_n   = '0;
          fail_n  = '0;
          first_n = '0;
          z0m_n   = '0;
          z1m_n   = '0;
        end
      end
      WAIT: begin
        if (abort) begin
          state_n = IDLE;
          pass_n  = 1'b0;
        end else begin
          cnt_n = cnt + 8'd1;
          if (cnt == SETTLE_M1)
            state_n = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_n = IDLE;
          pass_n  = 1'b0;
        end else begin
          z0m_n[takt] = z_0;
          z1m_n[takt] = z_1;
          if (mismatch) begin
            fail_n[takt] = 1'b1;
            err_n        = err_cnt + 4'd1;
            if (err_cnt == 4'd0)
              first_n = takt;
          end
          if (takt == 3'd7) begin
            state_n = DONE;
            pass_n  = (err_n == 4'd0);
          end else begin
            state_n = WAIT;
            takt_n  = takt + 3'd1;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == WAIT) || (state_n == CHECK);
    done_n = (state_n == DONE);
    // In DONE takt rests at 7, so x keeps showing the last vector.
    x_n    = (state_n == IDLE) ? 3'd0 : takt_n;
  end

endmodule

// File: tb/tb_lab1_seq_ctrl.sv
// Directed bench for lab1_seq_ctrl: table of full runs against
// several faulty logic-block models plus multi-cycle corner cases.
module tb_lab1_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, start6;
  logic       x_0, x_1, x_2, z_0, z_1;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_map, z0_map, z1_map;
  logic [2:0] first_fail;

  logic       y_0, y_1, y_2, w_0, w_1;
  logic       busy6, done6, pass6;
  logic [3:0] err6;
  logic [7:0] fm6, z0m6, z1m6;
  logic [2:0] ff6;

  logic [2:0] mode;
  logic [7:0] e0, e1;
  logic [2:0] x, y;
  logic [2:0] d3 [5];
  logic [2:0] d6 [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lab1_seq_ctrl #(.SETTLE(3)) dut (
    .clk(clk), .rst(rst),
    .start(start), .abort(abort),
    .x_0(x_0), .x_1(x_1), .x_2(x_2),
    .z_0(z_0), .z_1(z_1),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_map(fail_map),
    .first_fail(first_fail),
    .z0_map(z0_map), .z1_map(z1_map)
  );

  lab1_seq_ctrl #(.SETTLE(6)) dut6 (
    .clk(clk), .rst(rst),
    .start(start6), .abort(1'b0),
    .x_0(y_0), .x_1(y_1), .x_2(y_2),
    .z_0(w_0), .z_1(w_1),
    .busy(busy6), .done(done6), .pass(pass6),
    .err_cnt(err6), .fail_map(fm6),
    .first_fail(ff6),
    .z0_map(z0m6), .z1_map(z1m6)
  );

  assign x = {x_2, x_1, x_0};
  assign y = {y_2, y_1, y_0};

  // 5-stage delay lines model a slow logic block.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        d3[i] <= 3'd0;
        d6[i] <= 3'd0;
      end
    end else begin
      d3[0] <= x;
      d6[0] <= y;
      for (int i = 1; i < 5; i++) begin
        d3[i] <= d3[i-1];
        d6[i] <= d6[i-1];
      end
    end
  end

  // 0 golden, 1 z0 stuck 0, 2 z1 stuck 1,
  // 3 z0 inverted, 4 delayed by 5 cycles
  always_comb begin
    z_0 = e0[x];
    z_1 = e1[x];
    case (mode)
      3'd1: z_0 = 1'b0;
      3'd2: z_1 = 1'b1;
      3'd3: z_0 = ~e0[x];
      3'd4: begin
        z_0 = e0[d3[4]];
        z_1 = e1[d3[4]];
      end
      default: ;
    endcase
    w_0 = e0[d6[4]];
    w_1 = e1[d6[4]];
  end

  typedef struct {
    logic [2:0] mode;
    logic       full;
    logic       pass;
    logic [3:0] err;
    logic [7:0] fm;
    logic [2:0] ff;
    logic [7:0] z0m;
    logic [7:0] z1m;
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    chk("done_timeout", {31'd0, done}, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, {29'd0, x}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_pass"}, {31'd0, pass}, 0);
    chk({tag, "_err"}, {28'd0, err_cnt}, 0);
    chk({tag, "_fm"}, {24'd0, fail_map}, 0);
    chk({tag, "_ff"}, {29'd0, first_fail}, 0);
    chk({tag, "_z0m"}, {24'd0, z0_map}, 0);
    chk({tag, "_z1m"}, {24'd0, z1_map}, 0);
  endtask

  initial begin
    int n;
    e0 = 8'hA5;
    e1 = 8'hF1;
    tbl[0] = '{3'd0, 1'b1, 1'b1, 4'd0,
               8'h00, 3'd0, 8'hA5, 8'hF1};
    tbl[1] = '{3'd1, 1'b1, 1'b0, 4'd4,
               8'hA5, 3'd0, 8'h00, 8'hF1};
    tbl[2] = '{3'd2, 1'b1, 1'b0, 4'd3,
               8'h0E, 3'd1, 8'hA5, 8'hFF};
    tbl[3] = '{3'd3, 1'b1, 1'b0, 4'd8,
               8'hFF, 3'd0, 8'h5A, 8'hF1};
    tbl[4] = '{3'd4, 1'b0, 1'b0, 4'd0,
               8'h00, 3'd0, 8'h00, 8'h00};

    mode = 3'd0;
    rst = 1'b1;
    start = 1'b0;
    start6 = 1'b0;
    abort = 1'b0;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();
    chk_zero("idle");

    // Golden run: each vector held SETTLE+1 = 4 cycles.
    run_start();
    for (int i = 0; i < 32; i++) begin
      chk("seq_x", {29'd0, x}, 32'(i / 4));
      chk("seq_busy", {31'd0, busy}, 1);
      step();
    end
    chk("seq_done", {31'd0, done}, 1);
    chk("seq_busy_end", {31'd0, busy}, 0);
    chk("seq_x_end", {29'd0, x}, 7);
    chk("seq_pass", {31'd0, pass}, 1);

    // Faulty run, then restart from DONE.
    mode = 3'd1;
    run_start();
    wait_done(n);
    chk("pre_fm", {24'd0, fail_map}, 32'hA5);
    run_start();
    chk("redo_done", {31'd0, done}, 0);
    chk("redo_busy", {31'd0, busy}, 1);
    chk("redo_fm", {24'd0, fail_map}, 0);
    chk("redo_err", {28'd0, err_cnt}, 0);
    chk("redo_x", {29'd0, x}, 0);

    // Start while busy is ignored.
    for (int i = 0; i < 10; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_x", {29'd0, x}, 2);
    wait_done(n);
    chk("busy_start_len", n, 21);

    // Abort in DONE is ignored.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_done", {31'd0, done}, 1);

    // Abort (with start) in WAIT of vector 4.
    run_start();
    for (int i = 0; i < 16; i++) step();
    chk("ab_x4", {29'd0, x}, 4);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_busy", {31'd0, busy}, 0);
    chk("ab_done", {31'd0, done}, 0);
    chk("ab_pass", {31'd0, pass}, 0);
    chk("ab_x", {29'd0, x}, 0);
    chk("ab_fm", {24'd0, fail_map}, 32'h05);
    chk("ab_err", {28'd0, err_cnt}, 2);
    chk("ab_z0m", {24'd0, z0_map}, 0);
    chk("ab_z1m", {24'd0, z1_map}, 32'h01);
    step();
    chk("ab_idle", {31'd0, busy}, 0);
    mode = 3'd0;
    run_start();
    wait_done(n);
    chk("ab_rerun_pass", {31'd0, pass}, 1);
    chk("ab_rerun_err", {28'd0, err_cnt}, 0);

    // Reset at edge 20 of a faulty run.
    mode = 3'd1;
    run_start();
    for (int i = 0; i < 19; i++) step();
    chk("rst_pre_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    step();
    chk_zero("rst_mid");
    rst = 1'b0;
    step();
    chk("rst_idle", {31'd0, busy}, 0);

    for (int r = 0; r < 5; r++) begin
      mode = tbl[r].mode;
      start = 1'b1;
      start6 = (tbl[r].mode == 3'd4);
      step();
      start = 1'b0;
      start6 = 1'b0;
      wait_done(n);
      chk($sformatf("t%0d_pass", r),
          {31'd0, pass}, {31'd0, tbl[r].pass});
      if (tbl[r].full) begin
        chk($sformatf("t%0d_err", r),
            {28'd0, err_cnt}, {28'd0, tbl[r].err});
        chk($sformatf("t%0d_fm", r),
            {24'd0, fail_map}, {24'd0, tbl[r].fm});
        chk($sformatf("t%0d_ff", r),
            {29'd0, first_fail}, {29'd0, tbl[r].ff});
        chk($sformatf("t%0d_z0m", r),
            {24'd0, z0_map}, {24'd0, tbl[r].z0m});
        chk($sformatf("t%0d_z1m", r),
            {24'd0, z1_map}, {24'd0, tbl[r].z1m});
      end
    end

    // Same slow block with SETTLE=6 must pass.
    n = 0;
    while (!done6 && n < 200) begin
      step();
      n++;
    end
    chk("s6_done", {31'd0, done6}, 1);
    chk("s6_pass", {31'd0, pass6}, 1);
    chk("s6_err", {28'd0, err6}, 0);
    chk("s6_z0m", {24'd0, z0m6}, 32'hA5);
    chk("s6_z1m", {24'd0, z1m6}, 32'hF1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
